// File: rtl/camera_pkg.sv
// Shared types and constants for the pixel readout path of the 2x2 camera.
package camera_pkg;

  // Capture-side states: wait for row 1, settle the ADC, wait for row 2, commit
  typedef enum logic [1:0] {
    C_WAIT_R1,
    C_SETTLE,
    C_WAIT_R2,
    C_COMMIT
  } cap_state_t;

  localparam int PIX_PER_FRAME = 4;

  typedef logic [1:0] pix_idx_t;

  // Pixel numbering inside a frame: row-major, row 1 first
  localparam pix_idx_t IDX_R1C1 = 2'd0;
  localparam pix_idx_t IDX_R1C2 = 2'd1;
  localparam pix_idx_t IDX_R2C1 = 2'd2;
  localparam pix_idx_t IDX_R2C2 = 2'd3;

  // Slot index for a (row, column) pair; row2/col2 select the second row/column
  function automatic pix_idx_t slot_idx(input logic row2, input logic col2);
    return {row2, col2};
  endfunction

endpackage

// File: rtl/pixel_stream_tx.sv
// Output side of the readout: holds one committed frame and streams it
// one pixel per accepted valid/ready beat, index 0 through 3.
module pixel_stream_tx
  import camera_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    load,
  input  logic [PIX_PER_FRAME-1:0][DATA_W-1:0]    frame,
  input  logic                                    ready,
  output logic [DATA_W-1:0]                       data,
  output pix_idx_t                                index,
  output logic                                    valid,
  output logic                                    last,
  output logic                                    empty
);

  logic [PIX_PER_FRAME-1:0][DATA_W-1:0] frame_q;
  pix_idx_t                             idx_q;
  logic                                 full_q;
  logic                                 accept;
  logic                                 last_beat;
  logic                                 load_ok;

  assign accept    = full_q & ready;
  assign last_beat = accept & (idx_q == IDX_R2C2);
  // Empty as seen after this cycle's accept, so a commit can land on the final beat
  assign empty     = ~full_q | last_beat;
  assign load_ok   = load & empty;

  // Buffer occupancy and beat index; a load on the final beat restarts at index 0
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // the later load assignment deliberately overrides the accept update.
    if (reset) begin
      full_q <= 1'b0;
      idx_q  <= IDX_R1C1;
    end else begin
      if (accept)    idx_q  <= idx_q + 2'd1;
      if (last_beat) full_q <= 1'b0;
      if (load_ok) begin
        full_q <= 1'b1;
        idx_q  <= IDX_R1C1;
      end
    end
  end

  // Frame storage, written only on a successful load
  always_ff @(posedge clk) begin
    // NOTE: the pixel storage has no reset; data is qualified by full_q, so
    // clearing the array would only cost reset fan-out.
    if (load_ok) frame_q <= frame;
  end

  assign valid = full_q;
  assign index = idx_q;
  assign data  = full_q ? frame_q[idx_q] : '0;
  assign last  = full_q & (idx_q == IDX_R2C2);

endmodule

// File: rtl/pixel_readout_capture.sv
// Consumer end of the exposure readout: detects ADC strobes, samples both
// column ADCs for each selected row, assembles a 2x2 frame and hands it to
// the stream transmitter. Flags illegal strobes and dropped frames.
module pixel_readout_capture
  import camera_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADC_SETTLE = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              NRE_1,
  input  logic              NRE_2,
  input  logic              ADC,
  input  logic              Erase,
  input  logic [DATA_W-1:0] Adc_Col1,
  input  logic [DATA_W-1:0] Adc_Col2,
  output logic [DATA_W-1:0] Pix_Data,
  output logic [1:0]        Pix_Index,
  output logic              Pix_Valid,
  input  logic              Pix_Ready,
  output logic              Frame_Last,
  output logic              Overrun,
  output logic              Protocol_Err
);

  localparam logic [3:0] SETTLE_LAST = 4'(ADC_SETTLE);

  cap_state_t                           state;
  logic                                 adc_q;
  logic                                 row2;
  logic [3:0]                           settle_cnt;
  logic [PIX_PER_FRAME-1:0][DATA_W-1:0] slots;
  logic                                 adc_event;
  logic                                 row_sel_ok;
  logic                                 sample;
  logic                                 tx_empty;
  logic                                 tx_load;

  assign adc_event  = ADC & ~adc_q;
  // Exactly one row enable must be asserted when the ADC strobe rises
  assign row_sel_ok = NRE_1 ^ NRE_2;
  assign sample     = (state == C_SETTLE) & ~Erase & (settle_cnt == SETTLE_LAST);
  assign tx_load    = (state == C_COMMIT) & tx_empty;

  // ADC strobe history for rising-edge detection
  always_ff @(posedge Clk) begin
    if (Reset) adc_q <= 1'b0;
    else       adc_q <= ADC;
  end

  // Capture FSM with the sticky protocol/overrun flags as registered outputs.
  // Strobe edges are only acted on in the two wait states; one in flight at a time.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= C_WAIT_R1;
      row2         <= 1'b0;
      settle_cnt   <= '0;
      Overrun      <= 1'b0;
      Protocol_Err <= 1'b0;
    end else begin
      case (state)
        C_WAIT_R1: begin
          if (!Erase && adc_event) begin
            if (row_sel_ok && !NRE_1) begin
              row2       <= 1'b0;
              settle_cnt <= '0;
              state      <= C_SETTLE;
            end else begin
              Protocol_Err <= 1'b1;
            end
          end
        end
        C_WAIT_R2: begin
          if (Erase) begin
            state <= C_WAIT_R1;
          end else if (adc_event) begin
            if (row_sel_ok) begin
              // NRE_1 high here means NRE_2 is the one asserted; row 1 may be redone
              row2       <= NRE_1;
              settle_cnt <= '0;
              state      <= C_SETTLE;
            end else begin
              Protocol_Err <= 1'b1;
            end
          end
        end
        C_SETTLE: begin
          if (Erase) begin
            state <= C_WAIT_R1;
          end else if (sample) begin
            state <= row2 ? C_COMMIT : C_WAIT_R2;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        C_COMMIT: begin
          if (!tx_empty) Overrun <= 1'b1;
          state <= C_WAIT_R1;
        end
        default: state <= C_WAIT_R1;
      endcase
    end
  end

  // Capture slots: both columns of the selected row, written at the end of settling
  always_ff @(posedge Clk) begin
    if (sample) begin
      slots[slot_idx(row2, 1'b0)] <= Adc_Col1;
      slots[slot_idx(row2, 1'b1)] <= Adc_Col2;
    end
  end

  pixel_stream_tx #(
    .DATA_W (DATA_W)
  ) u_stream_tx (
    .clk   (Clk),
    .reset (Reset),
    .load  (tx_load),
    .frame (slots),
    .ready (Pix_Ready),
    .data  (Pix_Data),
    .index (Pix_Index),
    .valid (Pix_Valid),
    .last  (Frame_Last),
    .empty (tx_empty)
  );

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Directed bench for pixel_readout_capture: normal frame, backpressure,
// overrun, protocol errors, erase abort and reset in mid-stream.
module tb_pixel_readout_capture;

  localparam int DATA_W = 8;
  localparam int SETTLE = 2;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              NRE_1;
  logic              NRE_2;
  logic              ADC;
  logic              Erase;
  logic [DATA_W-1:0] Adc_Col1;
  logic [DATA_W-1:0] Adc_Col2;
  logic [DATA_W-1:0] Pix_Data;
  logic [1:0]        Pix_Index;
  logic              Pix_Valid;
  logic              Pix_Ready;
  logic              Frame_Last;
  logic              Overrun;
  logic              Protocol_Err;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_readout_capture #(
    .DATA_W     (DATA_W),
    .ADC_SETTLE (SETTLE)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .NRE_1        (NRE_1),
    .NRE_2        (NRE_2),
    .ADC          (ADC),
    .Erase        (Erase),
    .Adc_Col1     (Adc_Col1),
    .Adc_Col2     (Adc_Col2),
    .Pix_Data     (Pix_Data),
    .Pix_Index    (Pix_Index),
    .Pix_Valid    (Pix_Valid),
    .Pix_Ready    (Pix_Ready),
    .Frame_Last   (Frame_Last),
    .Overrun      (Overrun),
    .Protocol_Err (Protocol_Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // One row readout: strobe held through the settle window, then released
  task automatic cap_row(input int row, input logic [7:0] c1, input logic [7:0] c2);
    NRE_1    = (row == 1) ? 1'b0 : 1'b1;
    NRE_2    = (row == 2) ? 1'b0 : 1'b1;
    Adc_Col1 = c1;
    Adc_Col2 = c2;
    ADC      = 1'b1;
    repeat (SETTLE + 2) tick();
    ADC   = 1'b0;
    NRE_1 = 1'b1;
    NRE_2 = 1'b1;
    tick();
  endtask

  task automatic cap_frame(input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3);
    cap_row(1, p0, p1);
    cap_row(2, p2, p3);
  endtask

  // Single ADC strobe with an arbitrary row-enable pair
  task automatic strobe(input logic n1, input logic n2);
    NRE_1 = n1;
    NRE_2 = n2;
    ADC   = 1'b1;
    tick();
    ADC   = 1'b0;
    NRE_1 = 1'b1;
    NRE_2 = 1'b1;
    tick();
  endtask

  // Drain one frame; bp selects the 1,0,0 ready pattern and hold checks
  task automatic stream_frame(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3, input bit bp);
    logic [7:0] want [4];
    int         got   = 0;
    int         phase = 0;
    bit         held  = 1'b0;
    logic [7:0] hd    = '0;
    logic [1:0] hi    = '0;
    want = '{p0, p1, p2, p3};
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      Pix_Ready = bp ? (phase % 3 == 0) : 1'b1;
      phase++;
      if (held) begin
        check({tag, "_hold_valid"}, Pix_Valid, 1);
        check({tag, "_hold_data"},  Pix_Data,  hd);
        check({tag, "_hold_index"}, Pix_Index, hi);
      end
      held = 1'b0;
      if (!bp) check({tag, "_contig_valid"}, Pix_Valid, 1);
      if (Pix_Valid && Pix_Ready) begin
        check({tag, "_index"}, Pix_Index, got);
        check({tag, "_data"},  Pix_Data,  want[got]);
        check({tag, "_last"},  Frame_Last, (got == 3));
        got++;
      end else if (Pix_Valid) begin
        held = 1'b1;
        hd   = Pix_Data;
        hi   = Pix_Index;
      end
      tick();
    end
    check({tag, "_beats"}, got, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    Reset     = 1'b1;
    NRE_1     = 1'b1;
    NRE_2     = 1'b1;
    ADC       = 1'b0;
    Erase     = 1'b0;
    Adc_Col1  = '0;
    Adc_Col2  = '0;
    Pix_Ready = 1'b1;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state
    check("rst_valid", Pix_Valid,    0);
    check("rst_data",  Pix_Data,     0);
    check("rst_index", Pix_Index,    0);
    check("rst_last",  Frame_Last,   0);
    check("rst_ovr",   Overrun,      0);
    check("rst_perr",  Protocol_Err, 0);

    // Normal frame with latency check: commit cycle, then valid
    cap_row(1, 8'h11, 8'h22);
    NRE_1 = 1'b1; NRE_2 = 1'b0; Adc_Col1 = 8'h33; Adc_Col2 = 8'h44; ADC = 1'b1;
    repeat (SETTLE + 2) tick();
    check("lat_commit_valid", Pix_Valid, 0);
    ADC = 1'b0; NRE_2 = 1'b1;
    tick();
    check("lat_first_valid", Pix_Valid, 1);
    stream_frame("norm", 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    check("norm_idle_valid", Pix_Valid,    0);
    check("norm_ovr",        Overrun,      0);
    check("norm_perr",       Protocol_Err, 0);

    // Backpressure
    cap_frame(8'h11, 8'h22, 8'h33, 8'h44);
    stream_frame("bp", 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    tick();
    check("bp_idle_valid", Pix_Valid, 0);

    // Overrun: second frame dropped while the first is still unread
    do_reset();
    Pix_Ready = 1'b0;
    cap_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    check("ovr_first_valid", Pix_Valid, 1);
    check("ovr_first_flag",  Overrun,   0);
    cap_frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    check("ovr_second_flag", Overrun,   1);
    check("ovr_held_data",   Pix_Data,  8'hA0);
    stream_frame("ovr", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0);
    check("ovr_no_second_frame", Pix_Valid, 0);
    check("ovr_sticky",          Overrun,   1);

    // Protocol errors: both enables low, both high, row 2 first
    do_reset();
    strobe(1'b0, 1'b0);
    check("perr_both_low",  Protocol_Err, 1);
    check("perr_no_sample", Pix_Valid,    0);
    cap_frame(8'h21, 8'h22, 8'h23, 8'h24);
    stream_frame("perr_a", 8'h21, 8'h22, 8'h23, 8'h24, 1'b0);
    do_reset();
    strobe(1'b1, 1'b1);
    check("perr_both_high", Protocol_Err, 1);
    do_reset();
    strobe(1'b1, 1'b0);
    check("perr_row2_first", Protocol_Err, 1);
    cap_frame(8'h31, 8'h32, 8'h33, 8'h34);
    stream_frame("perr_b", 8'h31, 8'h32, 8'h33, 8'h34, 1'b0);
    check("perr_ovr", Overrun, 0);

    // Erase abort: row 2 right after the erase must be rejected
    do_reset();
    cap_row(1, 8'h55, 8'h66);
    Erase = 1'b1;
    tick();
    Erase = 1'b0;
    cap_row(2, 8'h77, 8'h88);
    check("erase_row2_rejected", Protocol_Err, 1);
    check("erase_no_frame",      Pix_Valid,    0);
    cap_row(1, 8'h55, 8'h66);
    Erase = 1'b1;
    tick();
    Erase = 1'b0;
    cap_frame(8'h01, 8'h02, 8'h03, 8'h04);
    stream_frame("erase", 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    check("erase_idle_valid", Pix_Valid, 0);

    // Reset in mid-stream after two accepted beats
    do_reset();
    strobe(1'b0, 1'b0);
    check("mid_perr_before", Protocol_Err, 1);
    Pix_Ready = 1'b0;
    cap_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    Pix_Ready = 1'b1;
    check("mid_beat0_index", Pix_Index, 0);
    tick();
    check("mid_beat1_index", Pix_Index, 1);
    check("mid_beat1_data",  Pix_Data,  8'hC2);
    tick();
    check("mid_beat2_index", Pix_Index, 2);
    Reset     = 1'b1;
    Pix_Ready = 1'b0;
    tick();
    Reset = 1'b0;
    check("mid_rst_valid", Pix_Valid,    0);
    check("mid_rst_index", Pix_Index,    0);
    check("mid_rst_data",  Pix_Data,     0);
    check("mid_rst_last",  Frame_Last,   0);
    check("mid_rst_perr",  Protocol_Err, 0);
    check("mid_rst_ovr",   Overrun,      0);
    Pix_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_leftover", Pix_Valid, 0);
    end
    cap_frame(8'hD1, 8'hD2, 8'hD3, 8'hD4);
    stream_frame("post_rst", 8'hD1, 8'hD2, 8'hD3, 8'hD4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
